digit_compose: RTL

Sequential decimal-entry accumulator: takes one decimal digit per keypress strobe, builds the binary value most-significant digit first (entry = entry*10 + d), supports delete, clear and commit, and hands the finished 21-bit value to downstream logic through a valid/ready handshake. It is the inverse path of the binary-to-tube digit decomposition and sits between the debounced keypad/switch front end and the calculator datapath. The live `entry` output feeds the display path so the user sees digits as they are typed.

---
 rtl/digit_compose_pkg.sv | 15 +
 rtl/digit_compose_if.sv | 11 +
 rtl/digit_compose_mul10_add.sv | 22 ++
 rtl/digit_compose.sv | 119 +++++++++++
 4 files changed

// File: rtl/digit_compose_pkg.sv
// Shared constants and state encoding for the decimal-entry accumulator.
// Optional feature macro: DIGIT_COMPOSE_SAT_EN (saturate on overflow instead of reject).
package digit_compose_pkg;

  localparam int COMPOSE_WIDTH = 21;
  localparam int COMPOSE_MAX   = (1 << COMPOSE_WIDTH) - 1;  // 2,097,151
  localparam int MAX_DIGITS    = 7;

  typedef enum logic [1:0] {
    COMPOSE_EMPTY = 2'd0,
    COMPOSE_ENTRY = 2'd1,
    COMPOSE_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/digit_compose_if.sv
// Result handshake between digit_compose (master) and the calculator datapath (slave).
interface digit_compose_if;

  logic                                      value_valid;
  logic                                      value_ready;
  logic [digit_compose_pkg::COMPOSE_WIDTH-1:0] value;

  modport master (output value_valid, output value, input  value_ready);
  modport slave  (input  value_valid, input  value, output value_ready);

endinterface

// File: rtl/digit_compose_mul10_add.sv
// Combinational x*10+d using shifts, with overflow flag against the largest entry.
module mul10_add
  import digit_compose_pkg::*;
(
  input  logic [COMPOSE_WIDTH-1:0] x,
  input  logic [3:0]               d,
  output logic [COMPOSE_WIDTH-1:0] y,
  output logic                     ovf
);

  localparam int WIDE = COMPOSE_WIDTH + 4;

  logic [WIDE-1:0] x_wide;
  logic [WIDE-1:0] sum;

  // Four guard bits hold 10*(2^21-1)+9 exactly, so the compare sees the true value.
  assign x_wide = {4'b0, x};
  assign sum    = (x_wide << 3) + (x_wide << 1) + {{(WIDE-4){1'b0}}, d};
  assign y      = sum[COMPOSE_WIDTH-1:0];
  assign ovf    = sum > WIDE'(COMPOSE_MAX);

endmodule

// File: rtl/digit_compose.sv
// Decimal keypad accumulator: builds a binary value MSD-first, offers it on a valid/ready port.
// Build option: define DIGIT_COMPOSE_SAT_EN to saturate on overflow rather than reject.
module digit_compose
  import digit_compose_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     digit_valid,
  input  logic [3:0]               digit,
  input  logic                     del,
  input  logic                     clr,
  input  logic                     commit,
  digit_compose_if.master          res,
  output logic [COMPOSE_WIDTH-1:0] entry,
  output logic [2:0]               count,
  output logic                     err
);

  state_t                   state, state_n;
  logic [COMPOSE_WIDTH-1:0] entry_n, value_n, mac_y;
  logic [2:0]               count_n;
  logic                     valid_n, err_n, mac_ovf;

  mul10_add u_mac (
    .x   (entry),
    .d   (digit),
    .y   (mac_y),
    .ovf (mac_ovf)
  );

  // NOTE: every next-value gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_n = state;
    entry_n = entry;
    count_n = count;
    value_n = res.value;
    valid_n = res.value_valid;
    err_n   = 1'b0;

    case (state)
      COMPOSE_EMPTY, COMPOSE_ENTRY: begin
        if (clr) begin
          entry_n = '0;
          count_n = '0;
          state_n = COMPOSE_EMPTY;
        end else if (commit) begin
          if (state == COMPOSE_ENTRY) begin
            value_n = entry;
            valid_n = 1'b1;
            state_n = COMPOSE_HOLD;
          end else begin
            err_n = 1'b1;
          end
        end else if (del) begin
          if (state == COMPOSE_ENTRY) begin
            entry_n = entry / COMPOSE_WIDTH'(10);
            count_n = count - 3'd1;
            if (count == 3'd1) state_n = COMPOSE_EMPTY;
          end else begin
            err_n = 1'b1;
          end
        end else if (digit_valid) begin
          if (digit > 4'd9 || count == 3'(MAX_DIGITS)) begin
            err_n = 1'b1;
          end else if (mac_ovf) begin
            err_n = 1'b1;
`ifdef DIGIT_COMPOSE_SAT_EN
            // Pinning count at the limit blocks further digits until del/clr.
            entry_n = COMPOSE_WIDTH'(COMPOSE_MAX);
            count_n = 3'(MAX_DIGITS);
            state_n = COMPOSE_ENTRY;
`endif
          end else begin
            entry_n = mac_y;
            count_n = count + 3'd1;
            state_n = COMPOSE_ENTRY;
          end
        end
      end

      COMPOSE_HOLD: begin
        // Completed transfer and withdrawal both land in EMPTY with the entry wiped.
        if (res.value_ready || clr) begin
          valid_n = 1'b0;
          entry_n = '0;
          count_n = '0;
          state_n = COMPOSE_EMPTY;
        end
      end

      default: begin
        valid_n = 1'b0;
        entry_n = '0;
        count_n = '0;
        state_n = COMPOSE_EMPTY;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= COMPOSE_EMPTY;
      entry           <= '0;
      count           <= '0;
      err             <= 1'b0;
      res.value       <= '0;
      res.value_valid <= 1'b0;
    end else begin
      state           <= state_n;
      entry           <= entry_n;
      count           <= count_n;
      err             <= err_n;
      res.value       <= value_n;
      res.value_valid <= valid_n;
    end
  end

endmodule
